// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, host and RAM port bundle of vram_arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
);
  logic              RGB_EN;
  logic              FRAME_START;
  logic              DISP_REQ;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic              DISP_GNT;
  logic [DATA_W-1:0] DISP_RDATA;
  logic              DISP_RVALID;
  logic              HOST_VALID;
  logic              HOST_WE;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic [DATA_W-1:0] HOST_WDATA;
  logic              HOST_READY;
  logic [DATA_W-1:0] HOST_RDATA;
  logic              HOST_RVALID;
  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              UNDERRUN;

  modport slave (
    input  RGB_EN, FRAME_START,
    input  DISP_REQ, DISP_ADDR,
    output DISP_GNT, DISP_RDATA, DISP_RVALID,
    input  HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
    output HOST_READY, HOST_RDATA, HOST_RVALID,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA,
    output UNDERRUN
  );

  modport master (
    output RGB_EN, FRAME_START,
    output DISP_REQ, DISP_ADDR,
    input  DISP_GNT, DISP_RDATA, DISP_RVALID,
    output HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
    input  HOST_READY, HOST_RDATA, HOST_RVALID,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA,
    input  UNDERRUN
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display fetch and host.
// Optional VRAM_HOST_STARVE_GUARD_EN: host starvation guard in active video.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STALL_MAX  = 4,
  parameter int STARVE_LIM = 16
) (
  input logic         CLK,
  input logic         RST,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_HOST
  } state_t;

  localparam int SW = $clog2(STALL_MAX + 1);

  state_t            state, state_nx;
  logic              st_host;
  logic              force_host;
  logic              disp_gnt, host_rdy;
  logic              disp_hs, host_hs;
  logic              stall;
  logic [SW-1:0]     stall_cnt;
  logic              underrun_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        tag_q [MEM_LAT+1];
  logic [1:0]        tag_out;
  logic              disp_rv, host_rv;
  logic [DATA_W-1:0] disp_hold, host_hold;

`ifdef VRAM_HOST_STARVE_GUARD_EN
  localparam int HW = $clog2(STARVE_LIM + 1);
  logic [HW-1:0] wait_cnt;

  assign force_host = bus.RGB_EN && !st_host &&
                      (wait_cnt == HW'(STARVE_LIM));

  // host wait counter, saturating, cleared by a host handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      wait_cnt <= '0;
    else if (host_hs)
      wait_cnt <= '0;
    else if (bus.HOST_VALID && !host_rdy &&
             wait_cnt != HW'(STARVE_LIM))
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  logic unused_guard;
  assign force_host   = 1'b0;
  assign unused_guard = ^{st_host, STARVE_LIM[0]};
`endif

  // priority grant: display in active video, host in blanking
  always_comb begin
    disp_gnt = 1'b0;
    host_rdy = 1'b0;
    if (!RST) begin
      if (bus.RGB_EN && !force_host) begin
        disp_gnt = bus.DISP_REQ;
        host_rdy = bus.HOST_VALID & ~bus.DISP_REQ;
      end else begin
        host_rdy = bus.HOST_VALID;
        disp_gnt = bus.DISP_REQ & ~bus.HOST_VALID;
      end
    end
  end

  assign disp_hs = bus.DISP_REQ & disp_gnt;
  assign host_hs = bus.HOST_VALID & host_rdy;
  assign stall   = bus.DISP_REQ & ~disp_gnt;

  // last-owner state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next owner follows this cycle's handshake
  always_comb begin
    unique case (1'b1)
      disp_hs: state_nx = S_DISP;
      host_hs: state_nx = S_HOST;
      default: state_nx = S_IDLE;
    endcase
  end

  // state decode used by the starvation guard
  always_comb begin
    st_host = (state == S_HOST);
  end

  // registered RAM port, loaded from the handshake winner
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= disp_hs | host_hs;
      mem_we_q <= host_hs & bus.HOST_WE;
      if (disp_hs) begin
        mem_addr_q  <= bus.DISP_ADDR;
        mem_wdata_q <= '0;
      end else if (host_hs) begin
        mem_addr_q  <= bus.HOST_ADDR;
        mem_wdata_q <= bus.HOST_WDATA;
      end
    end
  end

  // read tags {valid, owner}; owner 1 = host, writes carry no tag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i <= MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {disp_hs | (host_hs & ~bus.HOST_WE), host_hs};
      for (int i = 1; i <= MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[MEM_LAT];
  assign disp_rv = tag_out[1] & ~tag_out[0];
  assign host_rv = tag_out[1] & tag_out[0];

  // each owner's read data holds its last returned word
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      disp_hold <= '0;
      host_hold <= '0;
    end else begin
      if (disp_rv) disp_hold <= bus.MEM_RDATA;
      if (host_rv) host_hold <= bus.MEM_RDATA;
    end
  end

  // display stall counter and sticky underrun flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (disp_hs)
        stall_cnt <= '0;
      else if (stall && stall_cnt != SW'(STALL_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (stall && stall_cnt >= SW'(STALL_MAX - 1))
        underrun_q <= 1'b1;
      else if (bus.FRAME_START)
        underrun_q <= 1'b0;
    end
  end

  assign bus.DISP_GNT    = disp_gnt;
  assign bus.HOST_READY  = host_rdy;
  assign bus.DISP_RVALID = disp_rv;
  assign bus.HOST_RVALID = host_rv;
  assign bus.DISP_RDATA  = disp_rv ? bus.MEM_RDATA : disp_hold;
  assign bus.HOST_RDATA  = host_rv ? bus.MEM_RDATA : host_hold;
  assign bus.MEM_EN      = mem_en_q;
  assign bus.MEM_WE      = mem_we_q;
  assign bus.MEM_ADDR    = mem_addr_q;
  assign bus.MEM_WDATA   = mem_wdata_q;
  assign bus.UNDERRUN    = underrun_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter.
// RAM is modelled here with a MEM_LAT-deep read pipe.
module tb_vram_arbiter;
  localparam int AW  = 19;
  localparam int DW  = 32;
  localparam int LAT = 3;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rv_cnt  = 0;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .MEM_LAT(LAT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return {a[12:0], a} ^ 32'hA500_0000;
  endfunction

  // RAM model
  logic [DW-1:0] ram [logic [AW-1:0]];
  logic [DW-1:0] rd_pipe [LAT];

  always @(posedge CLK) begin
    if (bus.MEM_EN && bus.MEM_WE) ram[bus.MEM_ADDR] = bus.MEM_WDATA;
    if (bus.MEM_EN && !bus.MEM_WE)
      rd_pipe[0] <= ram.exists(bus.MEM_ADDR) ?
                    ram[bus.MEM_ADDR] : seed(bus.MEM_ADDR);
    else
      rd_pipe[0] <= 32'hBADC_0DE0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.MEM_RDATA = rd_pipe[LAT-1];

  // scoreboard
  exp_t          dq[$];
  exp_t          hq[$];
  exp_t          e;
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic          iss_v = 1'b0;
  logic          iss_w;
  logic [AW-1:0] iss_a;
  logic          dh, hh, de, he;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : seed(a);
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      dq.delete();
      hq.delete();
      iss_v = 1'b0;
    end else begin
      chk("mem_en", bus.MEM_EN, iss_v);
      if (iss_v) begin
        chk("mem_addr", bus.MEM_ADDR, iss_a);
        chk("mem_we", bus.MEM_WE, iss_w);
      end
      if (bus.DISP_RVALID) rv_cnt++;
      if (bus.HOST_RVALID) rv_cnt++;
      de = 1'b0;
      if (dq.size() != 0) de = (dq[0].due == cyc);
      chk("disp_rvalid", bus.DISP_RVALID, de);
      if (de) begin
        e = dq.pop_front();
        if (bus.DISP_RVALID) chk("disp_rdata", bus.DISP_RDATA, e.data);
      end
      he = 1'b0;
      if (hq.size() != 0) he = (hq[0].due == cyc);
      chk("host_rvalid", bus.HOST_RVALID, he);
      if (he) begin
        e = hq.pop_front();
        if (bus.HOST_RVALID) chk("host_rdata", bus.HOST_RDATA, e.data);
      end
      dh = bus.DISP_REQ & bus.DISP_GNT;
      hh = bus.HOST_VALID & bus.HOST_READY;
      chk("one_hs", dh & hh, 1'b0);
      iss_v = dh | hh;
      iss_w = hh & bus.HOST_WE;
      iss_a = dh ? bus.DISP_ADDR : bus.HOST_ADDR;
      if (dh) dq.push_back('{model_rd(bus.DISP_ADDR), cyc + 1 + LAT});
      if (hh) begin
        if (bus.HOST_WE) exp_mem[bus.HOST_ADDR] = bus.HOST_WDATA;
        else hq.push_back('{model_rd(bus.HOST_ADDR), cyc + 1 + LAT});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  int t;
  int first;
  int n_h;
  bit found;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    RST             = 1'b1;
    bus.RGB_EN      = 1'b0;
    bus.FRAME_START = 1'b0;
    bus.DISP_REQ    = 1'b1;
    bus.DISP_ADDR   = '0;
    bus.HOST_VALID  = 1'b1;
    bus.HOST_WE     = 1'b0;
    bus.HOST_ADDR   = '0;
    bus.HOST_WDATA  = '0;

    // reset state
    @(negedge CLK);
    chk("rst_ctl", {bus.DISP_GNT, bus.HOST_READY, bus.MEM_EN,
                    bus.MEM_WE, bus.UNDERRUN, bus.DISP_RVALID,
                    bus.HOST_RVALID}, 0);
    chk("rst_mem", {bus.MEM_ADDR, bus.MEM_WDATA}, 0);
    chk("rst_rdata", {bus.DISP_RDATA, bus.HOST_RDATA}, 0);
    step();
    RST            = 1'b0;
    bus.DISP_REQ   = 1'b0;
    bus.HOST_VALID = 1'b0;
    idle(2);

    // active-video contention
    bus.RGB_EN     = 1'b1;
    bus.DISP_REQ   = 1'b1;
    bus.HOST_VALID = 1'b1;
    bus.HOST_ADDR  = 19'h00777;
    for (int i = 0; i < 3; i++) begin
      bus.DISP_ADDR = 19'h01000 + AW'(i);
      @(negedge CLK);
      chk("act_dgnt", bus.DISP_GNT, 1'b1);
      chk("act_hrdy", bus.HOST_READY, 1'b0);
      step();
    end
    bus.DISP_REQ = 1'b0;
    @(negedge CLK);
    chk("act_host_after", bus.HOST_READY, 1'b1);
    step();
    bus.HOST_VALID = 1'b0;
    idle(LAT + 3);

    // blanking: host first, write then read back
    bus.RGB_EN     = 1'b0;
    bus.DISP_REQ   = 1'b1;
    bus.DISP_ADDR  = 19'h02000;
    bus.HOST_VALID = 1'b1;
    bus.HOST_WE    = 1'b1;
    bus.HOST_ADDR  = 19'h12345;
    bus.HOST_WDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("blank_hrdy", bus.HOST_READY, 1'b1);
    chk("blank_dgnt", bus.DISP_GNT, 1'b0);
    step();
    bus.HOST_WE = 1'b0;
    @(negedge CLK);
    chk("blank_rd_hrdy", bus.HOST_READY, 1'b1);
    t = cyc;
    step();
    bus.HOST_VALID = 1'b0;
    @(negedge CLK);
    chk("blank_disp_next", bus.DISP_GNT, 1'b1);
    step();
    bus.DISP_REQ = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (bus.HOST_RVALID && !found) begin
        found = 1'b1;
        chk("blank_rdata", bus.HOST_RDATA, 32'hDEAD_BEEF);
        chk("blank_lat", cyc - t, 1 + LAT);
      end
    end
    chk("blank_seen", found, 1'b1);
    chk("blank_no_underrun", bus.UNDERRUN, 1'b0);
    step();

    // interleaved routing: disp A, host B, disp C
    bus.RGB_EN    = 1'b1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 19'h03000;
    @(negedge CLK);
    chk("il_a", bus.DISP_GNT, 1'b1);
    step();
    bus.DISP_REQ   = 1'b0;
    bus.HOST_VALID = 1'b1;
    bus.HOST_ADDR  = 19'h12345;
    @(negedge CLK);
    chk("il_b", bus.HOST_READY, 1'b1);
    step();
    bus.HOST_VALID = 1'b0;
    bus.DISP_REQ   = 1'b1;
    bus.DISP_ADDR  = 19'h03004;
    @(negedge CLK);
    chk("il_c", bus.DISP_GNT, 1'b1);
    step();
    bus.DISP_REQ = 1'b0;
    idle(LAT + 3);

    // underrun rise, stickiness and frame clear
    bus.RGB_EN     = 1'b0;
    bus.HOST_VALID = 1'b1;
    bus.HOST_ADDR  = 19'h00400;
    bus.DISP_REQ   = 1'b1;
    bus.DISP_ADDR  = 19'h05000;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk("ur_rise", bus.UNDERRUN, k >= 5);
      step();
    end
    bus.HOST_VALID = 1'b0;
    @(negedge CLK);
    chk("ur_dgnt", bus.DISP_GNT, 1'b1);
    chk("ur_sticky", bus.UNDERRUN, 1'b1);
    step();
    bus.DISP_REQ    = 1'b0;
    bus.FRAME_START = 1'b1;
    @(negedge CLK);
    chk("ur_hold", bus.UNDERRUN, 1'b1);
    step();
    bus.FRAME_START = 1'b0;
    @(negedge CLK);
    chk("ur_clear", bus.UNDERRUN, 1'b0);
    step();

    // set wins over a coincident FRAME_START
    bus.HOST_VALID = 1'b1;
    bus.DISP_REQ   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus.FRAME_START = 1'b1;
      @(negedge CLK);
      chk("ur_pre", bus.UNDERRUN, 1'b0);
      step();
    end
    bus.FRAME_START = 1'b0;
    bus.HOST_VALID  = 1'b0;
    @(negedge CLK);
    chk("ur_set_wins", bus.UNDERRUN, 1'b1);
    step();
    bus.DISP_REQ    = 1'b0;
    bus.FRAME_START = 1'b1;
    step();
    bus.FRAME_START = 1'b0;
    idle(LAT + 3);

`ifdef VRAM_HOST_STARVE_GUARD_EN
    // starvation guard: one host grant after 16 wait cycles
    bus.RGB_EN     = 1'b1;
    bus.DISP_REQ   = 1'b1;
    bus.DISP_ADDR  = 19'h06100;
    bus.HOST_VALID = 1'b1;
    bus.HOST_ADDR  = 19'h06200;
    first = 0;
    n_h   = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge CLK);
      if (first != 0 && k == first + 1)
        chk("starve_regain", bus.DISP_GNT, 1'b1);
      if (bus.HOST_READY) begin
        n_h++;
        if (first == 0) first = k;
      end
      step();
    end
    chk("starve_first", first, 17);
    chk("starve_once", n_h, 1);
    bus.DISP_REQ   = 1'b0;
    bus.HOST_VALID = 1'b0;
    idle(LAT + 3);
`endif

    // reset during an in-flight display read
    bus.RGB_EN    = 1'b1;
    bus.DISP_REQ  = 1'b1;
    bus.DISP_ADDR = 19'h06000;
    @(negedge CLK);
    chk("rr_dgnt", bus.DISP_GNT, 1'b1);
    step();
    bus.DISP_REQ = 1'b0;
    RST          = 1'b1;
    #1;
    chk("rr_mem_en", bus.MEM_EN, 1'b0);
    chk("rr_outs", {bus.DISP_GNT, bus.HOST_READY, bus.UNDERRUN,
                    bus.DISP_RVALID, bus.HOST_RVALID}, 0);
    chk("rr_rdata", {bus.DISP_RDATA, bus.HOST_RDATA}, 0);
    idle(2);
    RST    = 1'b0;
    rv_cnt = 0;
    idle(LAT + 4);
    chk("rr_no_rvalid", rv_cnt, 0);

    chk("drain", dq.size() + hq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port synchronous video RAM between the display fetch path (pixel words for the VGA timing controller) and a host read/write port.
- Active video (RGB_EN=1): display has strict priority.
- Blanking (RGB_EN=0): host has priority.
- Drives the RAM through a registered memory port and routes read data back to the owner through a latency-matched tag pipeline.
- Flags display underrun per frame.

Parameters:
ADDR_W, 19, address width (640x480 words fits)
DATA_W, 32, RAM word width (4 x 8-bit pixels)
MEM_LAT, 1, RAM read latency in cycles, legal 1..4
STALL_MAX, 4, display wait cycles that trigger UNDERRUN
STARVE_LIM, 16, host wait limit (optional feature only)

Ports:
CLK  in  1  system/pixel clock, all logic posedge
RST  in  1  asynchronous, active-high reset
RGB_EN  in  1  active-video flag from timing controller
FRAME_START  in  1  one-cycle pulse at frame start; clears UNDERRUN
DISP_REQ  in  1  display fetch request, held until DISP_GNT
DISP_ADDR  in  ADDR_W  display fetch address
DISP_GNT  out  1  display handshake, combinational
DISP_RDATA  out  DATA_W  display read data
DISP_RVALID  out  1  DISP_RDATA valid
HOST_VALID  in  1  host request valid
HOST_WE  in  1  1=write, 0=read
HOST_ADDR  in  ADDR_W  host address
HOST_WDATA  in  DATA_W  host write data
HOST_READY  out  1  host handshake, combinational
HOST_RDATA  out  DATA_W  host read data
HOST_RVALID  out  1  HOST_RDATA valid
MEM_EN  out  1  RAM access strobe, registered
MEM_WE  out  1  RAM write enable, registered
MEM_ADDR  out  ADDR_W  RAM address, registered
MEM_WDATA  out  DATA_W  RAM write data, registered
MEM_RDATA  in  DATA_W  RAM read data, valid MEM_LAT cycles after the MEM_EN cycle
UNDERRUN  out  1  sticky display-stall flag

Behaviour:
- Reset (async, RST=1): all outputs 0; tag pipe cleared; stall counter 0; FSM to IDLE. In-flight reads are dropped and no RVALID is produced for them.
- Throughput: at most one access per cycle. Handshake happens at the edge where REQ&GNT or VALID&READY is high.
- Issue timing: MEM_EN/WE/ADDR/WDATA are registered from the winner and are high for exactly the cycle after the handshake edge. MEM_EN=0 otherwise, and MEM_WE=0 whenever MEM_EN=0.
- Grant rule when RGB_EN=1: DISP_GNT=DISP_REQ; HOST_READY=HOST_VALID & ~DISP_REQ.
- Grant rule when RGB_EN=0: HOST_READY=HOST_VALID; DISP_GNT=DISP_REQ & ~HOST_VALID.
- Grant hold: grants never depend on prior grants, so back-to-back handshakes are allowed.
- FSM (tracks last owner):
  - IDLE -> DISP on display handshake.
  - IDLE -> HOST on host handshake.
  - DISP/HOST -> the other state on a handshake by the other requester.
  - Any state -> IDLE on a cycle with no handshake.
  - State has no effect on priority unless the optional feature is compiled in.
- Tag pipeline: MEM_LAT+1 stages carrying {valid, owner} for reads only; writes insert an invalid tag.
  - On tag exit, MEM_RDATA goes to the owner's RDATA and that RVALID pulses high for one cycle.
  - The other RDATA holds its last value.
  - Display read handshake at edge t gives DISP_RVALID in the cycle after edge t+1+MEM_LAT-1 (MEM_LAT=1: two cycles after the handshake cycle).
- Ordering: read data returns in issue order per owner. A host write followed by a host read of the same address returns the new data.
- Stall counter (saturating at STALL_MAX):
  - Increments each cycle DISP_REQ=1 & DISP_GNT=0.
  - Clears on a display handshake.
  - Reaching STALL_MAX sets UNDERRUN.
  - UNDERRUN stays set until FRAME_START or RST. If FRAME_START and a set condition coincide, set wins.
- RGB_EN toggling with a request pending: priority follows the current-cycle RGB_EN only. No request is lost; it simply waits.
- Address/data widths pass through unchanged; no arithmetic on addresses.

Optional Feature:
- Macro: VRAM_HOST_STARVE_GUARD_EN.
- When defined:
  - A host wait counter (0..STARVE_LIM) increments each cycle HOST_VALID=1 & HOST_READY=0 and clears on a host handshake.
  - At STARVE_LIM during RGB_EN=1, the host wins the next contended cycle (HOST_READY=1, DISP_GNT=0), but only if the FSM is not already in HOST; then the counter clears.
  - The display stall counter still applies.
- When undefined: no counter; strict priority as above; the host can starve indefinitely during active video.

Test Plan:
- Reset mid-read: DISP handshake, assert RST next cycle -> all outputs 0, no DISP_RVALID after release, MEM_EN=0.
- Active contention: RGB_EN=1, DISP_REQ and HOST_VALID held 3 cycles -> DISP_GNT 3 cycles, HOST_READY 0, MEM_ADDR=DISP_ADDR; host granted on first cycle DISP_REQ=0.
- Blanking priority: RGB_EN=0, both requesting -> HOST_READY=1, DISP_GNT=0; write 0xDEADBEEF to 0x12345, then read 0x12345 -> HOST_RVALID with 0xDEADBEEF two cycles after the read handshake.
- Latency/routing: MEM_LAT=3, interleaved disp read A, host read B, disp read C -> RVALIDs in order disp,host,disp, each 4 cycles after its handshake, with correct data.
- Underrun: RGB_EN=0, HOST_VALID held, DISP_REQ held 4 cycles -> UNDERRUN=1 at cycle 4; FRAME_START pulse -> UNDERRUN=0.
- Starve guard (macro on, STARVE_LIM=16): RGB_EN=1, both held -> host granted exactly once at wait cycle 16, display regains the grant next cycle.
